// File: rtl/gf180mcu_fd_sc_mcu9t5v0__oai32_bist.sv
// BIST sweep for an oai32 cell: walks all 32 input vectors, samples ZN after
// SETTLE idle cycles and compares it to !((A1|A2|A3) & (B1|B2)).
module gf180mcu_fd_sc_mcu9t5v0__oai32_bist #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       START,
    input  logic       ZN_OBS,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       B1,
    output logic       B2,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [4:0] FAIL_VEC,
    output logic [5:0] ERR_CNT,
    inout  wire        VDD,
    inout  wire        VSS
);

    localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_vec;
    logic [3:0] r_cnt;
    logic [5:0] r_err_cnt;
    logic [4:0] r_fail_vec;
    logic       r_first_fail;

    logic       w_exp;
    logic       w_mismatch;
    logic       w_sample;
    logic       w_last;
    logic       w_start;
    logic       w_unused;

    // Supply pins carry no logic; folded here only so they are referenced.
    assign w_unused = VDD ^ VSS;

    assign w_exp      = ~((|r_vec[2:0]) & (|r_vec[4:3]));
    // Case inequality so an X or Z on the observed pin counts as a failure.
    assign w_mismatch = (ZN_OBS !== w_exp);
    assign w_sample   = (r_state == S_RUN) && (r_cnt == 4'd0);
    assign w_last     = w_sample && (r_vec == 5'd31);
    assign w_start    = START && (r_state != S_RUN);

    always_ff @(posedge CLK or posedge R) begin
        if (R) r_state <= S_IDLE;
        else   r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (START)  w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            r_vec        <= 5'd0;
            r_cnt        <= 4'd0;
            r_err_cnt    <= 6'd0;
            r_fail_vec   <= 5'd0;
            r_first_fail <= 1'b0;
        end else if (w_start) begin
            r_vec        <= 5'd0;
            r_cnt        <= LP_SETTLE;
            r_err_cnt    <= 6'd0;
            r_fail_vec   <= 5'd0;
            r_first_fail <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                if (w_mismatch) begin
                    r_err_cnt <= r_err_cnt + 6'd1;
                    if (!r_first_fail) begin
                        r_fail_vec   <= r_vec;
                        r_first_fail <= 1'b1;
                    end
                end
                // Last vector returns the cell drives to 0 while results hold.
                if (r_vec != 5'd31) begin
                    r_vec <= r_vec + 5'd1;
                    r_cnt <= LP_SETTLE;
                end else begin
                    r_vec <= 5'd0;
                end
            end
        end
    end

    assign A1       = r_vec[0];
    assign A2       = r_vec[1];
    assign A3       = r_vec[2];
    assign B1       = r_vec[3];
    assign B2       = r_vec[4];
    assign BUSY     = (r_state == S_RUN);
    assign DONE     = (r_state == S_DONE);
    assign PASS     = DONE && (r_err_cnt == 6'd0);
    assign FAIL_VEC = r_fail_vec;
    assign ERR_CNT  = r_err_cnt;

endmodule
